// File: rtl/led_shift_sequencer_pkg.sv
// Shared definitions for the LED shift sequencer: sizes, mode/state encodings,
// and the ring position step used by the position mirror.
package led_shift_sequencer_pkg;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned POS_W       = $clog2(WIDTH);
    localparam int unsigned PAUSE_TICKS = 4;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned MODE_W      = 2;
    localparam int unsigned LEN_W       = 4;

    localparam logic [MODE_W-1:0] MODE_MANUAL = 2'd0;
    localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BURST  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_SWEEP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_RUN    = 2'd2,
        ST_PAUSE  = 2'd3
    } state_e;

    // One ring step: dir=1 moves toward the MSB, dir=0 toward the LSB, wrapping.
    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p, input logic d);
        if (d) begin
            return (p == POS_W'(WIDTH - 1)) ? '0 : p + POS_W'(1);
        end
        return (p == '0) ? POS_W'(WIDTH - 1) : p - POS_W'(1);
    endfunction

endpackage

// File: rtl/led_shift_sequencer_rise_detect.sv
// Rising-edge detector: remembers the previous level and flags a 0->1 change.
module led_shift_sequencer_rise_detect (
    input  logic clk_div,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // Previous-cycle copy of the input level.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/led_shift_sequencer.sv
// Sequencer driving en/dir of the 16-LED one-hot rotating shifter, with a
// position mirror of the lit LED so direction decisions never read the LED bus.
module led_shift_sequencer
    import led_shift_sequencer_pkg::*;
(
    input  logic              clk_div,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              man_en_i,
    input  logic              man_dir_i,
    input  logic [LEN_W-1:0]  burst_len_i,
    output logic              en_o,
    output logic              dir_o,
    output logic [POS_W-1:0]  pos_o,
    output logic              busy_o,
    output logic              evt_o
);

    state_e              state_q;
    logic [POS_W-1:0]    pos_q;
    logic [POS_W-1:0]    pos_d;
    logic                dir_q;
    logic [CNT_W-1:0]    step_cnt_q;
    logic [CNT_W-1:0]    pause_cnt_q;
    logic [MODE_W-1:0]   mode_q;
    logic [CNT_W-1:0]    len_q;
    logic                start_rise;
    logic                en_c;
    logic                dir_c;
    logic                evt_c;

    led_shift_sequencer_rise_detect u_start_rise (
        .clk_div (clk_div),
        .rst     (rst),
        .sig_i   (start_i),
        .rise_o  (start_rise)
    );

    // Output decode from registered state; only MANUAL passes inputs straight through.
    always_comb begin
        en_c  = 1'b0;
        dir_c = dir_q;
        evt_c = 1'b0;
        case (state_q)
            ST_MANUAL: begin
                en_c  = man_en_i;
                dir_c = man_dir_i;
            end
            ST_RUN: begin
                en_c = 1'b1;
                case (mode_q)
                    MODE_BOUNCE: evt_c = (dir_q  && (pos_q == POS_W'(WIDTH - 2))) ||
                                         (!dir_q && (pos_q == POS_W'(1)));
                    MODE_BURST:  evt_c = (step_cnt_q == (len_q - CNT_W'(1)));
                    MODE_SWEEP:  evt_c = (step_cnt_q == CNT_W'(WIDTH - 1));
                    default:     evt_c = 1'b0;
                endcase
            end
            default: begin
                en_c  = 1'b0;
                dir_c = dir_q;
            end
        endcase
        pos_d = en_c ? step_pos(pos_q, dir_c) : pos_q;
    end

    // Sequencer state, counters, latched start parameters and position mirror.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pos_q       <= POS_W'(WIDTH - 1);
            dir_q       <= 1'b0;
            step_cnt_q  <= '0;
            pause_cnt_q <= '0;
            mode_q      <= MODE_MANUAL;
            len_q       <= CNT_W'(WIDTH);
        end else begin
            pos_q <= pos_d;
            if (stop_i) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_rise) begin
                            mode_q <= mode_i;
                            len_q  <= (burst_len_i == '0) ? CNT_W'(WIDTH) : CNT_W'(burst_len_i);
                            case (mode_i)
                                MODE_MANUAL: state_q <= ST_MANUAL;
                                MODE_BOUNCE: begin
                                    state_q <= ST_RUN;
                                    // Never start a bounce by walking off an end of the ring.
                                    if (pos_q == POS_W'(WIDTH - 1)) begin
                                        dir_q <= 1'b0;
                                    end else if (pos_q == '0) begin
                                        dir_q <= 1'b1;
                                    end else begin
                                        dir_q <= man_dir_i;
                                    end
                                end
                                default: begin
                                    state_q    <= ST_RUN;
                                    dir_q      <= man_dir_i;
                                    step_cnt_q <= '0;
                                end
                            endcase
                        end
                    end
                    ST_RUN: begin
                        step_cnt_q <= step_cnt_q + CNT_W'(1);
                        if (evt_c) begin
                            case (mode_q)
                                MODE_BOUNCE: dir_q <= ~dir_q;
                                MODE_BURST: begin
                                    state_q     <= ST_PAUSE;
                                    pause_cnt_q <= '0;
                                end
                                MODE_SWEEP:  state_q <= ST_IDLE;
                                default:     state_q <= ST_IDLE;
                            endcase
                        end
                    end
                    ST_PAUSE: begin
                        pause_cnt_q <= pause_cnt_q + CNT_W'(1);
                        if (pause_cnt_q == CNT_W'(PAUSE_TICKS - 1)) begin
                            state_q    <= ST_RUN;
                            step_cnt_q <= '0;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign en_o   = en_c;
    assign dir_o  = dir_c;
    assign pos_o  = pos_q;
    assign busy_o = (state_q != ST_IDLE);
    assign evt_o  = evt_c;

endmodule

// File: tb/tb_led_shift_sequencer.sv
// Scoreboard bench for led_shift_sequencer: the driver queues the expected
// outputs for each checked cycle, a negedge monitor pops and compares them.
module tb_led_shift_sequencer;

    logic       clk_div;
    logic       rst;
    logic       start_i;
    logic       stop_i;
    logic [1:0] mode_i;
    logic       man_en_i;
    logic       man_dir_i;
    logic [3:0] burst_len_i;
    logic       en_o;
    logic       dir_o;
    logic [3:0] pos_o;
    logic       busy_o;
    logic       evt_o;

    typedef struct {
        string      name;
        logic [7:0] vec;   // {en, dir, pos[3:0], busy, evt}
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic drv_done = 1'b0;

    led_shift_sequencer dut (
        .clk_div     (clk_div),
        .rst         (rst),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .mode_i      (mode_i),
        .man_en_i    (man_en_i),
        .man_dir_i   (man_dir_i),
        .burst_len_i (burst_len_i),
        .en_o        (en_o),
        .dir_o       (dir_o),
        .pos_o       (pos_o),
        .busy_o      (busy_o),
        .evt_o       (evt_o)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    // Queue the outputs expected during the current cycle, then advance one cycle.
    task automatic cyc(input string nm, input logic e_en, input logic e_dir,
                       input logic e_busy, input logic e_evt, input logic [3:0] e_pos);
        exp_t e;
        e.name = nm;
        e.vec  = {e_en, e_dir, e_pos, e_busy, e_evt};
        sb_q.push_back(e);
        @(posedge clk_div);
        #1;
    endtask

    // Monitor: compare mid-cycle, away from the active edge.
    always @(negedge clk_div) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = sb_q.pop_front();
            act = {en_o, dir_o, pos_o, busy_o, evt_o};
            n_checks++;
            if (act !== e.vec) begin
                n_fail++;
                $display("FAIL %s @%0t: got en=%b dir=%b pos=%0d busy=%b evt=%b, expected en=%b dir=%b pos=%0d busy=%b evt=%b",
                         e.name, $time, act[7], act[6], act[5:2], act[1], act[0],
                         e.vec[7], e.vec[6], e.vec[5:2], e.vec[1], e.vec[0]);
            end
        end
    end

    // Driver: directed sequences with hand-derived expectations.
    initial begin
        rst = 1'b1; start_i = 1'b1; stop_i = 1'b0; mode_i = 2'd1;
        man_en_i = 1'b0; man_dir_i = 1'b1; burst_len_i = 4'd3;
        @(posedge clk_div);
        #1;
        // Reset values; start held high during reset has no effect.
        cyc("reset", 0, 0, 0, 0, 4'd15);
        rst = 1'b0; start_i = 1'b0;
        cyc("idle_after_reset", 0, 0, 0, 0, 4'd15);

        // Bounce from pos 15: direction forced right despite man_dir=1.
        mode_i = 2'd1; man_dir_i = 1'b1; start_i = 1'b1;
        cyc("bounce_start", 0, 0, 0, 0, 4'd15);
        start_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc("bounce_down", 1, 0, 1, (i == 14), 4'(15 - i));
        end
        for (int p = 0; p < 15; p++) begin
            cyc("bounce_up", 1, 1, 1, (p == 14), 4'(p));
        end
        // Stop during RUN: the enabled shift still lands, then IDLE.
        stop_i = 1'b1;
        cyc("bounce_top_stop", 1, 0, 1, 0, 4'd15);
        stop_i = 1'b0;
        cyc("stop_idle", 0, 0, 0, 0, 4'd14);

        // Manual: en/dir follow inputs in the same cycle, pos tracks.
        mode_i = 2'd0; start_i = 1'b1;
        cyc("manual_start", 0, 0, 0, 0, 4'd14);
        start_i = 1'b0; man_en_i = 1'b0; man_dir_i = 1'b1;
        cyc("manual_hold", 0, 1, 1, 0, 4'd14);
        man_en_i = 1'b1;
        cyc("manual_left", 1, 1, 1, 0, 4'd14);
        man_dir_i = 1'b0;
        cyc("manual_right", 1, 0, 1, 0, 4'd15);
        man_dir_i = 1'b1;
        cyc("manual_left2", 1, 1, 1, 0, 4'd14);
        man_en_i = 1'b0; stop_i = 1'b1;
        cyc("manual_stop", 0, 1, 1, 0, 4'd15);
        stop_i = 1'b0;
        cyc("manual_idle", 0, 0, 0, 0, 4'd15);

        // start and stop together in IDLE: stays IDLE.
        start_i = 1'b1; stop_i = 1'b1;
        cyc("collide", 0, 0, 0, 0, 4'd15);
        stop_i = 1'b0;
        cyc("collide_idle", 0, 0, 0, 0, 4'd15);
        start_i = 1'b0;
        cyc("collide_release", 0, 0, 0, 0, 4'd15);

        // Burst of 3 from pos 15 going left; later mode/len changes ignored.
        mode_i = 2'd2; burst_len_i = 4'd3; man_dir_i = 1'b1; start_i = 1'b1;
        cyc("burst_start", 0, 0, 0, 0, 4'd15);
        start_i = 1'b0; mode_i = 2'd3; burst_len_i = 4'd7;
        cyc("burst_run", 1, 1, 1, 0, 4'd15);
        cyc("burst_run", 1, 1, 1, 0, 4'd0);
        cyc("burst_run_evt", 1, 1, 1, 1, 4'd1);
        for (int i = 0; i < 4; i++) begin
            cyc("burst_pause", 0, 1, 1, 0, 4'd2);
        end
        cyc("burst2_run", 1, 1, 1, 0, 4'd2);
        cyc("burst2_run", 1, 1, 1, 0, 4'd3);
        cyc("burst2_run_evt", 1, 1, 1, 1, 4'd4);
        cyc("burst2_pause", 0, 1, 1, 0, 4'd5);
        // Asynchronous reset mid-pause takes effect within the cycle.
        rst = 1'b1;
        cyc("reset_mid_pause", 0, 0, 0, 0, 4'd15);
        rst = 1'b0;
        cyc("reset_idle", 0, 0, 0, 0, 4'd15);

        // Single sweep right from pos 15: 16 steps, back to 15, then idle.
        mode_i = 2'd3; man_dir_i = 1'b0; start_i = 1'b1;
        cyc("sweep_start", 0, 0, 0, 0, 4'd15);
        start_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc("sweep_run", 1, 0, 1, (i == 15), 4'(15 - i));
        end
        cyc("sweep_done", 0, 0, 0, 0, 4'd15);

        drv_done = 1'b1;
    end

    // Wrap-up: drain the scoreboard within a bounded wait, then summarize.
    initial begin
        int guard;
        guard = 0;
        while (!drv_done && guard < 5000) begin
            @(posedge clk_div);
            guard++;
        end
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
            @(posedge clk_div);
        end
        n_checks++;
        if (!drv_done || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: driver_done=%b pending=%0d, expected driver_done=1 pending=0",
                     drv_done, sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
